// File: rtl/m2_block_writer.sv
// m2_block_writer: packs a stream of 8-bit IDCT samples (64 per 8x8 block,
// row-major, blocks in raster order, segments Y/U/V) into 16-bit words and
// writes them to SRAM in the M1 input layout. All outputs are registered.
module m2_block_writer (
  input  logic        CLOCK_50_I,
  input  logic        reset,
  input  logic        m2w_start,
  input  logic        sample_valid,
  input  logic [7:0]  sample_data,
  output logic        sample_ready,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        m2w_end
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [17:0] U_BASE   = 18'd38400;
  localparam logic [17:0] V_BASE   = 18'd57600;
  localparam logic [17:0] WPR_Y    = 18'd160;
  localparam logic [17:0] WPR_UV   = 18'd80;
  localparam logic [17:0] BROW_Y   = 18'd1280;  // 8 rows of Y words
  localparam logic [17:0] BROW_UV  = 18'd640;   // 8 rows of U/V words
  localparam logic [5:0]  LCOL_Y   = 6'd39;
  localparam logic [5:0]  LCOL_UV  = 6'd19;

  logic [1:0]  state_q, state_d;
  logic        ready_q, ready_d;
  logic        we_n_q, we_n_d;
  logic        end_q, end_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;

  // Position counters. Addresses are tracked as running bases so that only
  // adders are needed: blkrow_base = start of current block row, block_base =
  // word 0 of current block, row_addr = word 0 of current row in the block.
  logic [1:0]  seg_q, seg_d;
  logic [4:0]  brow_q, brow_d;
  logic [5:0]  bcol_q, bcol_d;
  logic [2:0]  r_q, r_d;
  logic [1:0]  c_q, c_d;
  logic        odd_q, odd_d;
  logic [7:0]  held_q, held_d;
  logic [17:0] blkrow_base_q, blkrow_base_d;
  logic [17:0] block_base_q, block_base_d;
  logic [17:0] row_addr_q, row_addr_d;

  logic [17:0] wpr;
  logic [17:0] brow_step;
  logic [5:0]  last_col;
  logic        xfer;

  assign wpr       = (seg_q == 2'd0) ? WPR_Y  : WPR_UV;
  assign brow_step = (seg_q == 2'd0) ? BROW_Y : BROW_UV;
  assign last_col  = (seg_q == 2'd0) ? LCOL_Y : LCOL_UV;
  assign xfer      = sample_valid && ready_q;

  // Next-state: FSM, sample pairing, SRAM strobe and counter advance.
  always_comb begin
    state_d       = state_q;
    we_n_d        = 1'b1;
    end_d         = 1'b0;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    seg_d         = seg_q;
    brow_d        = brow_q;
    bcol_d        = bcol_q;
    r_d           = r_q;
    c_d           = c_q;
    odd_d         = odd_q;
    held_d        = held_q;
    blkrow_base_d = blkrow_base_q;
    block_base_d  = block_base_q;
    row_addr_d    = row_addr_q;
    case (state_q)
      S_IDLE: begin
        if (m2w_start) begin
          state_d       = S_RUN;
          seg_d         = 2'd0;
          brow_d        = 5'd0;
          bcol_d        = 6'd0;
          r_d           = 3'd0;
          c_d           = 2'd0;
          odd_d         = 1'b0;
          held_d        = 8'd0;
          blkrow_base_d = 18'd0;
          block_base_d  = 18'd0;
          row_addr_d    = 18'd0;
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (!odd_q) begin
            held_d = sample_data;
            odd_d  = 1'b1;
          end else begin
            odd_d   = 1'b0;
            we_n_d  = 1'b0;
            addr_d  = row_addr_q + {16'd0, c_q};
            wdata_d = {held_q, sample_data};
            if (c_q != 2'd3) begin
              c_d = c_q + 2'd1;
            end else begin
              c_d = 2'd0;
              if (r_q != 3'd7) begin
                r_d        = r_q + 3'd1;
                row_addr_d = row_addr_q + wpr;
              end else begin
                r_d = 3'd0;
                if (bcol_q != last_col) begin
                  bcol_d       = bcol_q + 6'd1;
                  block_base_d = block_base_q + 18'd4;
                  row_addr_d   = block_base_q + 18'd4;
                end else begin
                  bcol_d = 6'd0;
                  if (brow_q != 5'd29) begin
                    brow_d        = brow_q + 5'd1;
                    blkrow_base_d = blkrow_base_q + brow_step;
                    block_base_d  = blkrow_base_q + brow_step;
                    row_addr_d    = blkrow_base_q + brow_step;
                  end else begin
                    brow_d = 5'd0;
                    if (seg_q == 2'd2) begin
                      state_d = S_DONE;
                    end else begin
                      // Jump to the next segment's base explicitly.
                      seg_d         = seg_q + 2'd1;
                      blkrow_base_d = (seg_q == 2'd0) ? U_BASE : V_BASE;
                      block_base_d  = (seg_q == 2'd0) ? U_BASE : V_BASE;
                      row_addr_d    = (seg_q == 2'd0) ? U_BASE : V_BASE;
                    end
                  end
                end
              end
            end
          end
        end
      end
      S_DONE: begin
        end_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_RUN);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge CLOCK_50_I or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b0;
      we_n_q        <= 1'b1;
      end_q         <= 1'b0;
      addr_q        <= 18'd0;
      wdata_q       <= 16'd0;
      seg_q         <= 2'd0;
      brow_q        <= 5'd0;
      bcol_q        <= 6'd0;
      r_q           <= 3'd0;
      c_q           <= 2'd0;
      odd_q         <= 1'b0;
      held_q        <= 8'd0;
      blkrow_base_q <= 18'd0;
      block_base_q  <= 18'd0;
      row_addr_q    <= 18'd0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      we_n_q        <= we_n_d;
      end_q         <= end_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      seg_q         <= seg_d;
      brow_q        <= brow_d;
      bcol_q        <= bcol_d;
      r_q           <= r_d;
      c_q           <= c_d;
      odd_q         <= odd_d;
      held_q        <= held_d;
      blkrow_base_q <= blkrow_base_d;
      block_base_q  <= block_base_d;
      row_addr_q    <= row_addr_d;
    end
  end

  assign sample_ready    = ready_q;
  assign SRAM_we_n       = we_n_q;
  assign m2w_end         = end_q;
  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;

endmodule

// File: tb/tb_m2_block_writer.sv
// Directed bench for m2_block_writer: reset state, basic packing, stall and
// ignored start, full-frame address map, completion pulse, mid-frame reset.
module tb_m2_block_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        valid;
  logic [7:0]  data;
  logic        sample_ready;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        m2w_end;

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;

  logic [17:0] wa_q[$];
  logic [15:0] wd_q[$];
  int          wc_q[$];
  int          ec_q[$];
  bit          seen [0:76799];

  m2_block_writer dut (
    .CLOCK_50_I      (clk),
    .reset           (rst),
    .m2w_start       (start),
    .sample_valid    (valid),
    .sample_data     (data),
    .sample_ready    (sample_ready),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .m2w_end         (m2w_end)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write and completion pulse, sampled away from the rising edge.
  always @(negedge clk) begin
    if (SRAM_we_n === 1'b0) begin
      wa_q.push_back(SRAM_address);
      wd_q.push_back(SRAM_write_data);
      wc_q.push_back(cyc);
    end
    if (m2w_end === 1'b1) ec_q.push_back(cyc);
  end

  function automatic logic [7:0] samp(input int i);
    if (i == 0) return 8'h10;
    if (i == 1) return 8'h20;
    return 8'((i * 13 + 5) ^ (i >> 7));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Present samples [from,to); optional random one-cycle valid gaps.
  task automatic feed(input int from, input int to, input bit gaps);
    int i;
    i = from;
    while (i < to) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 15) == 0) begin
        valid = 1'b0;
      end else begin
        valid = 1'b1;
        data  = samp(i);
        i++;
      end
    end
    @(negedge clk) valid = 1'b0;
  endtask

  task automatic idle_ignore(input string tag);
    int n0;
    n0 = wa_q.size();
    repeat (3) begin
      @(negedge clk);
      valid = 1'b1;
      data  = 8'hAA;
    end
    @(negedge clk) valid = 1'b0;
    repeat (2) @(negedge clk);
    chk(tag, 32'(wa_q.size()), 32'(n0));
    chk({tag, "_ready"}, 32'(sample_ready), 32'd0);
  endtask

  initial begin
    int base, last, dups, oob;
    rst = 1'b1; start = 1'b0; valid = 1'b0; data = 8'd0;
    #5;
    chk("rst_ready", 32'(sample_ready), 32'd0);
    chk("rst_we_n",  32'(SRAM_we_n), 32'd1);
    chk("rst_end",   32'(m2w_end), 32'd0);
    chk("rst_addr",  32'(SRAM_address), 32'd0);
    chk("rst_data",  32'(SRAM_write_data), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    idle_ignore("idle_ignore");

    // Frame 1: basic word, stall with ignored start, then the whole frame.
    base = wa_q.size();
    do_start();
    chk("run_ready", 32'(sample_ready), 32'd1);
    feed(0, 1, 1'b0);
    chk("even_no_write", 32'(SRAM_we_n), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = (k == 2);
      chk("stall_we_n", 32'(SRAM_we_n), 32'd1);
    end
    start = 1'b0;
    chk("stall_ready", 32'(sample_ready), 32'd1);
    feed(1, 2, 1'b0);
    chk("basic_we_n", 32'(SRAM_we_n), 32'd0);
    chk("basic_addr", 32'(SRAM_address), 32'd0);
    chk("basic_data", 32'(SRAM_write_data), 32'h1020);
    @(negedge clk);
    chk("hold_we_n", 32'(SRAM_we_n), 32'd1);
    chk("hold_addr", 32'(SRAM_address), 32'd0);
    chk("hold_data", 32'(SRAM_write_data), 32'h1020);
    feed(2, 153600, 1'b1);
    repeat (4) @(negedge clk);

    chk("frame_writes", 32'(wa_q.size() - base), 32'd76800);
    chk("b0_row1",    32'(wa_q[base + 4]), 32'd160);
    chk("b0_row7end", 32'(wa_q[base + 31]), 32'd1123);
    chk("b1_first",   32'(wa_q[base + 32]), 32'd4);
    chk("b40_first",  32'(wa_q[base + 1280]), 32'd1280);
    chk("u_first",    32'(wa_q[base + 38400]), 32'd38400);
    chk("u_row1",     32'(wa_q[base + 38404]), 32'd38480);
    chk("v_first",    32'(wa_q[base + 57600]), 32'd57600);
    chk("last_addr",  32'(wa_q[base + 76799]), 32'd76799);
    chk("w1_data",    32'(wd_q[base + 1]), 32'({samp(2), samp(3)}));
    chk("last_data",  32'(wd_q[base + 76799]), 32'({samp(153598), samp(153599)}));
    dups = 0; oob = 0;
    for (int k = base; k < wa_q.size(); k++) begin
      if (wa_q[k] >= 18'd76800) oob++;
      else if (seen[int'(wa_q[k])]) dups++;
      else seen[int'(wa_q[k])] = 1'b1;
    end
    chk("dup_addr", 32'(dups), 32'd0);
    chk("oob_addr", 32'(oob), 32'd0);
    last = wc_q.size() - 1;
    chk("end_count", 32'(ec_q.size()), 32'd1);
    chk("end_timing", 32'(ec_q[0]), 32'(wc_q[last] + 1));
    chk("done_ready", 32'(sample_ready), 32'd0);
    idle_ignore("post_done_ignore");

    // Frame 2: restart at 0, then reset at word 500.
    do_start();
    feed(0, 2, 1'b0);
    chk("restart_we_n", 32'(SRAM_we_n), 32'd0);
    chk("restart_addr", 32'(SRAM_address), 32'd0);
    feed(2, 1001, 1'b0);
    chk("w499_addr", 32'(SRAM_address), 32'd703);
    #2 rst = 1'b1;
    #1;
    chk("mrst_ready", 32'(sample_ready), 32'd0);
    chk("mrst_we_n",  32'(SRAM_we_n), 32'd1);
    chk("mrst_end",   32'(m2w_end), 32'd0);
    chk("mrst_addr",  32'(SRAM_address), 32'd0);
    chk("mrst_data",  32'(SRAM_write_data), 32'd0);
    @(negedge clk) rst = 1'b0;
    idle_ignore("post_rst_ignore");
    do_start();
    feed(0, 2, 1'b0);
    chk("rst_restart_we_n", 32'(SRAM_we_n), 32'd0);
    chk("rst_restart_addr", 32'(SRAM_address), 32'd0);
    chk("rst_restart_data", 32'(SRAM_write_data), 32'h1020);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/m2_block_writer.md
M2_BLOCK_WRITER -- requirements
Module: m2_block_writer

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 SHALL provide these ports:
- CLOCK_50_I  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- m2w_start  in  1  one-cycle start pulse.
- sample_valid  in  1  sample_data is valid this cycle.
- sample_data  in  8  clipped 8-bit IDCT output sample.
- sample_ready  out  1  block accepts a sample this cycle.
- SRAM_address  out  18  SRAM word address.
- SRAM_write_data  out  16  packed sample pair.
- SRAM_we_n  out  1  active-low write strobe.
- m2w_end  out  1  one-cycle completion pulse.
REQ-003 SHALL register all outputs; no combinational path from any input to any output.

Function
REQ-004 SHALL write one full 320x240 YUV frame as 8x8 blocks into the M1 input layout:
- Y: base 0, 160 words/row, 40x30 blocks.
- U: base 38400, 80 words/row, 20x30 blocks.
- V: base 57600, 80 words/row, 20x30 blocks.
REQ-005 SHALL implement states S_IDLE, S_RUN, S_DONE.
REQ-006 S_IDLE: sample_ready=0, SRAM_we_n=1; m2w_start=1 clears all counters and enters S_RUN next cycle.
REQ-007 S_RUN: sample_ready=1. A sample transfer occurs when sample_valid && sample_ready.
REQ-008 Sample order:
- 64 samples per block, row-major within the block.
- Blocks in raster order within a segment.
- Segments in order Y, then U, then V.
REQ-009 An even-indexed sample within a row SHALL be held as the high byte. The next (odd-indexed) sample completes the word {held, odd}.
REQ-010 When a word completes, the block SHALL, in the following cycle, drive SRAM_write_data = {held, odd} and SRAM_we_n = 0 for exactly one cycle.
REQ-011 Write address SHALL be: seg_base + (block_row*8 + r)*words_per_row + block_col*4 + c, where r is 0..7 (row in block) and c is 0..3 (word in row).
REQ-012 Addresses SHALL be generated with incremental counters and adders only; no multipliers.
REQ-013 Counter wrap-around:
- c wraps 3->0 and increments r.
- r wraps 7->0 and increments block_col.
- block_col wraps at the segment's last column (39 for Y, 19 for U/V) and increments block_row.
- block_row wraps 29->0 and advances the segment Y->U->V.
REQ-014 sample_valid deasserted in S_RUN SHALL stall the block: counters, held byte and SRAM signals are unchanged and SRAM_we_n stays 1.
REQ-015 After the write of word 76799 (V block 19,29; r=7, c=3), the block SHALL enter S_DONE: sample_ready=0, m2w_end=1 for one cycle, then return to S_IDLE.
REQ-016 Samples presented outside S_RUN SHALL be ignored.
REQ-017 m2w_start asserted while in S_RUN or S_DONE SHALL be ignored.
REQ-018 SRAM_address and SRAM_write_data SHALL hold their last values while SRAM_we_n = 1.

Reset
REQ-019 reset=1 SHALL asynchronously force all of the following, including mid-frame:
- state=S_IDLE, sample_ready=0, SRAM_we_n=1, m2w_end=0.
- SRAM_address=0, SRAM_write_data=0.
- All counters and the held byte cleared.
REQ-020 After reset deasserts, the block SHALL stay in S_IDLE until m2w_start; a partially written frame is not resumed.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Basic write: start, then samples 0x10, 0x20 -> one cycle after the second transfer, SRAM_we_n=0, SRAM_address=0, SRAM_write_data=0x1020.
- Block 0 address sequence: feed block 0 -> row 1 first word at 160; row 7 last word at 7*160+3=1123. Block 1 first word at 4. Block 40 first word at 1280.
- Segment boundaries: after 1200 Y blocks, first U word at 38400 and U row 1 at 38480. After 600 U blocks, first V word at 57600.
- Full frame with random valid gaps: exactly 76800 writes, no address repeated. Last write at 76799. m2w_end pulses once, one cycle after it. A second start then restarts at address 0.
- Stall and ignore: sample_valid low for 5 cycles mid-word -> no write, held byte retained. start pulsed during S_RUN -> no effect on counters.
- Mid-frame reset: reset at word 500 -> outputs immediately take their REQ-019 values. Next start writes the first word at address 0.
